// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time and a one-cycle dead gap
// between grants. Every output is a flop, so there is no combinational path from req.
module rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] id_q, id_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       busy_q, busy_d;
    logic       preempt_q, preempt_d;
    logic       timeout;
    logic [1:0] winner;

    // First requester found when scanning upward from p, wrapping modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        w = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    // In GAP the pointer was already advanced at the GRANT->GAP edge.
    assign winner = pick(req, ptr_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        hold_cnt_d = hold_cnt_q;
        timeout    = 1'b0;
        case (state_q)
            S_IDLE, S_GAP: begin
                if (|req) begin
                    state_d    = S_GRANT;
                    id_d       = winner;
                    hold_cnt_d = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                timeout    = (hold_cnt_q == HOLD_LAST);
                if (!req[id_q] || timeout) begin
                    state_d = S_GAP;
                    ptr_d   = id_q + 2'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                id_d       = 2'd0;
                hold_cnt_d = 8'd0;
            end
        endcase

        // Outputs are precomputed from the next state and registered alongside it.
        gnt_d     = (state_d == S_GRANT) ? (4'b0001 << id_d) : 4'b0000;
        busy_d    = (state_d == S_GRANT);
        gnt_id_d  = id_d;
        preempt_d = (state_d == S_GAP) && timeout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= 2'd0;
            id_q       <= 2'd0;
            hold_cnt_q <= 8'd0;
            gnt_q      <= 4'b0000;
            gnt_id_q   <= 2'd0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Three arbiters (MAX_HOLD 16, 4, 1) driven by directed and random request patterns,
// each compared every cycle against a cycle-count model of the grant rules.
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a     [3];
    logic [3:0] gnt_a     [3];
    logic [1:0] gnt_id_a  [3];
    logic       busy_a    [3];
    logic       preempt_a [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_arbiter #(.MAX_HOLD(16)) u16 (.clk(clk), .rst(rst), .req(req_a[0]), .gnt(gnt_a[0]),
        .gnt_id(gnt_id_a[0]), .busy(busy_a[0]), .preempt(preempt_a[0]));
    rr_arbiter #(.MAX_HOLD(4))  u4  (.clk(clk), .rst(rst), .req(req_a[1]), .gnt(gnt_a[1]),
        .gnt_id(gnt_id_a[1]), .busy(busy_a[1]), .preempt(preempt_a[1]));
    rr_arbiter #(.MAX_HOLD(1))  u1  (.clk(clk), .rst(rst), .req(req_a[2]), .gnt(gnt_a[2]),
        .gnt_id(gnt_id_a[2]), .busy(busy_a[2]), .preempt(preempt_a[2]));

    // Model: owner = granted requester (-1 if none), held = cycles the grant has been visible.
    int mh      [3] = '{16, 4, 1};
    int m_owner [3];
    int m_held  [3];
    int m_ptr   [3];
    bit m_pre   [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int u);
        m_owner[u] = -1;
        m_held[u]  = 0;
        m_ptr[u]   = 0;
        m_pre[u]   = 1'b0;
    endtask

    task automatic model_step(input int u, input logic [3:0] r);
        m_pre[u] = 1'b0;
        if (m_owner[u] >= 0) begin
            m_held[u] = m_held[u] + 1;
            if (!r[m_owner[u]] || m_held[u] == mh[u]) begin
                m_pre[u]   = (m_held[u] == mh[u]);
                m_ptr[u]   = (m_owner[u] + 1) % 4;
                m_owner[u] = -1;
            end
        end else if (r != 4'b0000) begin
            for (int k = 3; k >= 0; k--)
                if (r[(m_ptr[u] + k) % 4]) m_owner[u] = (m_ptr[u] + k) % 4;
            m_held[u] = 0;
        end
    endtask

    task automatic check_all();
        logic [3:0] eg;
        for (int u = 0; u < 3; u++) begin
            eg = (m_owner[u] >= 0) ? 4'(1 << m_owner[u]) : 4'b0000;
            chk($sformatf("u%0d_gnt", u), 32'(gnt_a[u]), 32'(eg));
            chk($sformatf("u%0d_busy", u), 32'(busy_a[u]), 32'(m_owner[u] >= 0));
            chk($sformatf("u%0d_preempt", u), 32'(preempt_a[u]), 32'(m_pre[u]));
            if (m_owner[u] >= 0)
                chk($sformatf("u%0d_gnt_id", u), 32'(gnt_id_a[u]), 32'(m_owner[u]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int u = 0; u < 3; u++) begin
            if (rst) model_reset(u);
            else     model_step(u, req_a[u]);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_all(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        req_a[0] = a;
        req_a[1] = b;
        req_a[2] = c;
    endtask

    initial begin
        for (int u = 0; u < 3; u++) model_reset(u);
        set_all(4'b0000, 4'b0000, 4'b0000);

        // Reset state
        tick();
        tick();
        for (int u = 0; u < 3; u++)
            chk($sformatf("rst_gnt_id_u%0d", u), 32'(gnt_id_a[u]), 32'd0);
        rst = 1'b0;
        tick();

        // Single requester 2 for three cycles, then release
        req_a[0] = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_gnt", 32'(gnt_a[0]), 32'h4);
            chk("single_id", 32'(gnt_id_a[0]), 32'd2);
            chk("single_pre", 32'(preempt_a[0]), 32'd0);
        end
        req_a[0] = 4'b0000;
        tick();
        chk("single_gap", 32'(gnt_a[0]), 32'h0);
        chk("single_gap_pre", 32'(preempt_a[0]), 32'd0);
        tick();
        chk("single_idle", 32'(busy_a[0]), 32'd0);

        // All requesting: 16-cycle rotation, 4-cycle repeat of one, 1-cycle alternation
        sync_reset();
        set_all(4'b1111, 4'b0001, 4'b0011);
        for (int c = 0; c < 85; c++) begin
            tick();
            chk("rot16_gnt", 32'(gnt_a[0]), (c % 17 < 16) ? 32'(1 << ((c / 17) % 4)) : 32'h0);
            chk("rot16_pre", 32'(preempt_a[0]), 32'(c % 17 == 16));
            chk("hold4_gnt", 32'(gnt_a[1]), (c % 5 < 4) ? 32'h1 : 32'h0);
            chk("hold4_pre", 32'(preempt_a[1]), 32'(c % 5 == 4));
            chk("hold1_gnt", 32'(gnt_a[2]), (c % 4 == 0) ? 32'h1 : (c % 4 == 2) ? 32'h2 : 32'h0);
            chk("hold1_pre", 32'(preempt_a[2]), 32'(c % 2 == 1));
        end
        set_all(4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();

        // Pointer wrap from requester 3 to 0
        req_a[0] = 4'b1000;
        tick();
        chk("wrap_g3", 32'(gnt_a[0]), 32'h8);
        tick();
        req_a[0] = 4'b1001;
        tick();
        tick();
        chk("wrap_hold3", 32'(gnt_a[0]), 32'h8);
        req_a[0] = 4'b0001;
        tick();
        chk("wrap_gap", 32'(gnt_a[0]), 32'h0);
        chk("wrap_gap_pre", 32'(preempt_a[0]), 32'd0);
        tick();
        chk("wrap_g0", 32'(gnt_a[0]), 32'h1);
        chk("wrap_id0", 32'(gnt_id_a[0]), 32'd0);
        req_a[0] = 4'b0000;
        tick();
        tick();

        // Asynchronous reset mid-grant, between clock edges
        req_a[0] = 4'b0100;
        tick();
        tick();
        chk("arst_pre_gnt", 32'(gnt_a[0]), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt_a[0]), 32'h0);
        chk("arst_busy", 32'(busy_a[0]), 32'd0);
        for (int u = 0; u < 3; u++) model_reset(u);
        #1 rst = 1'b0;
        req_a[0] = 4'b1010;
        tick();
        chk("arst_after_gnt", 32'(gnt_a[0]), 32'h2);
        req_a[0] = 4'b0000;
        tick();
        tick();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            for (int u = 0; u < 3; u++)
                if ($urandom_range(0, 3) == 0) req_a[u] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) sync_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
